// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle controller and its datapath.
// The controller takes the master side; the datapath (or a bench) takes the slave side.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opCode;
  logic [5:0]       Funct;
  logic             ALUZero;
  logic             mem_ready;
  logic             mem_req;
  logic             IRWrite;
  logic             PCWrite;
  logic [1:0]       PCSrc;
  logic             RegWrite;
  logic             RegDst;
  logic             ALUSrc;
  logic             MemWrite;
  logic             MemtoReg;
  logic             EXTop;
  logic             writeR31;
  logic [2:0]       ALUop;
  logic [2:0]       state;
  logic             illegal;
  logic             retire;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  opCode, Funct, ALUZero, mem_ready,
    output mem_req, IRWrite, PCWrite, PCSrc, RegWrite, RegDst, ALUSrc, MemWrite,
           MemtoReg, EXTop, writeR31, ALUop, state, illegal, retire, instr_cnt
  );

  modport slave (
    output opCode, Funct, ALUZero, mem_ready,
    input  mem_req, IRWrite, PCWrite, PCSrc, RegWrite, RegDst, ALUSrc, MemWrite,
           MemtoReg, EXTop, writeR31, ALUop, state, illegal, retire, instr_cnt
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM: fetch/decode/exec/mem/writeback sequencing with
// memory handshake stalls and a retired-instruction counter.
module multicycle_ctrl #(
  parameter int CNT_W          = 32,
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  multicycle_ctrl_if.master bus
);
  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] HALT   = 3'd7;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_LUI = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       stateReg, stateNext;
  logic [CNT_W-1:0] cntReg;

  logic isR, isAddu, isSubu, isSll, isJr, isRAlu;
  logic isOri, isLui, isLw, isSw, isBeq, isJ, isJal, isLegal;
  logic [2:0] rAluOp, immAluOp;

  assign isR      = (bus.opCode == OP_RTYPE);
  assign isAddu   = isR && (bus.Funct == FN_ADDU);
  assign isSubu   = isR && (bus.Funct == FN_SUBU);
  assign isSll    = isR && (bus.Funct == FN_SLL);
  assign isJr     = isR && (bus.Funct == FN_JR);
  assign isRAlu   = isAddu || isSubu || isSll;
  assign isOri    = (bus.opCode == OP_ORI);
  assign isLui    = (bus.opCode == OP_LUI);
  assign isLw     = (bus.opCode == OP_LW);
  assign isSw     = (bus.opCode == OP_SW);
  assign isBeq    = (bus.opCode == OP_BEQ);
  assign isJ      = (bus.opCode == OP_J);
  assign isJal    = (bus.opCode == OP_JAL);
  assign isLegal  = isRAlu || isJr || isOri || isLui || isLw || isSw || isBeq || isJ || isJal;
  assign rAluOp   = isSubu ? ALU_SUB : (isSll ? ALU_SLL : ALU_ADD);
  assign immAluOp = isOri ? ALU_OR : ALU_LUI;

  logic memReq, irWrite, pcWrite, regWrite, regDst, aluSrc, memWrite, memtoReg;
  logic extOp, wrR31, illegal, retire;
  logic [1:0] pcSrc;
  logic [2:0] aluOp;

  always_comb begin
    memReq    = 1'b0;
    irWrite   = 1'b0;
    pcWrite   = 1'b0;
    pcSrc     = 2'b00;
    regWrite  = 1'b0;
    regDst    = 1'b0;
    aluSrc    = 1'b0;
    memWrite  = 1'b0;
    memtoReg  = 1'b0;
    extOp     = 1'b0;
    wrR31     = 1'b0;
    aluOp     = ALU_ADD;
    illegal   = 1'b0;
    retire    = 1'b0;
    stateNext = stateReg;
    case (stateReg)
      FETCH: begin
        memReq = 1'b1;
        if (bus.mem_ready) begin
          irWrite   = 1'b1;
          pcWrite   = 1'b1;
          stateNext = DECODE;
        end
      end
      DECODE: begin
        if (isJ || isJal) begin
          pcWrite   = 1'b1;
          pcSrc     = 2'b10;
          regWrite  = isJal;
          wrR31     = isJal;
          retire    = 1'b1;
          stateNext = FETCH;
        end else if (isJr) begin
          pcWrite   = 1'b1;
          pcSrc     = 2'b11;
          retire    = 1'b1;
          stateNext = FETCH;
        end else if (!isLegal) begin
          illegal = 1'b1;
          if (ILLEGAL_AS_NOP) begin
            retire    = 1'b1;
            stateNext = FETCH;
          end else begin
            stateNext = HALT;
          end
        end else begin
          stateNext = EXEC;
        end
      end
      EXEC: begin
        if (isRAlu) begin
          aluOp     = rAluOp;
          stateNext = WB;
        end else if (isOri || isLui) begin
          aluOp     = immAluOp;
          aluSrc    = 1'b1;
          extOp     = 1'b1;
          stateNext = WB;
        end else if (isLw || isSw) begin
          aluSrc    = 1'b1;
          stateNext = MEM;
        end else begin
          // Only beq reaches here; branch resolves without a writeback.
          aluOp     = ALU_SUB;
          pcSrc     = 2'b01;
          pcWrite   = bus.ALUZero;
          retire    = 1'b1;
          stateNext = FETCH;
        end
      end
      MEM: begin
        memReq = 1'b1;
        aluSrc = 1'b1;
        if (bus.mem_ready) begin
          if (isSw) begin
            memWrite  = 1'b1;
            retire    = 1'b1;
            stateNext = FETCH;
          end else begin
            stateNext = WB;
          end
        end
      end
      WB: begin
        regWrite  = 1'b1;
        retire    = 1'b1;
        stateNext = FETCH;
        memtoReg  = isLw;
        regDst    = isRAlu;
        if (isOri || isLui) begin
          aluOp  = immAluOp;
          aluSrc = 1'b1;
          extOp  = 1'b1;
        end
      end
      HALT:    stateNext = HALT;
      default: stateNext = FETCH;
    endcase
    // Reset silences every control at once so an in-flight store cannot land.
    if (!reset) begin
      memReq   = 1'b0;
      irWrite  = 1'b0;
      pcWrite  = 1'b0;
      pcSrc    = 2'b00;
      regWrite = 1'b0;
      regDst   = 1'b0;
      aluSrc   = 1'b0;
      memWrite = 1'b0;
      memtoReg = 1'b0;
      extOp    = 1'b0;
      wrR31    = 1'b0;
      aluOp    = ALU_ADD;
      illegal  = 1'b0;
      retire   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg <= FETCH;
      cntReg   <= '0;
    end else begin
      stateReg <= stateNext;
      if (retire) cntReg <= cntReg + CNT_ONE;
    end
  end

  assign bus.mem_req   = memReq;
  assign bus.IRWrite   = irWrite;
  assign bus.PCWrite   = pcWrite;
  assign bus.PCSrc     = pcSrc;
  assign bus.RegWrite  = regWrite;
  assign bus.RegDst    = regDst;
  assign bus.ALUSrc    = aluSrc;
  assign bus.MemWrite  = memWrite;
  assign bus.MemtoReg  = memtoReg;
  assign bus.EXTop     = extOp;
  assign bus.writeR31  = wrR31;
  assign bus.ALUop     = aluOp;
  assign bus.state     = stateReg;
  assign bus.illegal   = illegal;
  assign bus.retire    = retire;
  assign bus.instr_cnt = cntReg;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a halting instance (32-bit counter) and a nop-on-illegal
// instance (2-bit counter, exercises wrap) share the same stimulus.
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] opCode = '0;
  logic [5:0] funct = '0;
  logic aluZero = 1'b0;
  logic memReady = 1'b0;

  multicycle_ctrl_if #(.CNT_W(32)) ifA();
  multicycle_ctrl_if #(.CNT_W(2))  ifB();

  assign ifA.opCode = opCode;
  assign ifA.Funct = funct;
  assign ifA.ALUZero = aluZero;
  assign ifA.mem_ready = memReady;
  assign ifB.opCode = opCode;
  assign ifB.Funct = funct;
  assign ifB.ALUZero = aluZero;
  assign ifB.mem_ready = memReady;

  multicycle_ctrl #(.CNT_W(32), .ILLEGAL_AS_NOP(1'b0)) dutA (.clk(clk), .reset(reset), .bus(ifA.master));
  multicycle_ctrl #(.CNT_W(2),  .ILLEGAL_AS_NOP(1'b1)) dutB (.clk(clk), .reset(reset), .bus(ifB.master));

  typedef struct packed {
    logic       memReq;
    logic       irWrite;
    logic       pcWrite;
    logic [1:0] pcSrc;
    logic       regWrite;
    logic       regDst;
    logic       aluSrc;
    logic       memWrite;
    logic       memtoReg;
    logic       extOp;
    logic       writeR31;
    logic [2:0] aluOp;
    logic       illegal;
    logic       retire;
  } ctrl_t;

  ctrl_t actA, actB;
  assign actA = {ifA.mem_req, ifA.IRWrite, ifA.PCWrite, ifA.PCSrc, ifA.RegWrite, ifA.RegDst,
                 ifA.ALUSrc, ifA.MemWrite, ifA.MemtoReg, ifA.EXTop, ifA.writeR31, ifA.ALUop,
                 ifA.illegal, ifA.retire};
  assign actB = {ifB.mem_req, ifB.IRWrite, ifB.PCWrite, ifB.PCSrc, ifB.RegWrite, ifB.RegDst,
                 ifB.ALUSrc, ifB.MemWrite, ifB.MemtoReg, ifB.EXTop, ifB.writeR31, ifB.ALUop,
                 ifB.illegal, ifB.retire};

  localparam logic [2:0] S_FETCH = 3'd0, S_DEC = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd7;

  localparam ctrl_t C_ZERO     = '0;
  localparam ctrl_t C_FETCH    = '{memReq:1'b1, irWrite:1'b1, pcWrite:1'b1, default:'0};
  localparam ctrl_t C_FWAIT    = '{memReq:1'b1, default:'0};
  localparam ctrl_t C_EX_SUB   = '{aluOp:3'b001, default:'0};
  localparam ctrl_t C_EX_SLL   = '{aluOp:3'b100, default:'0};
  localparam ctrl_t C_WB_R     = '{regWrite:1'b1, regDst:1'b1, retire:1'b1, default:'0};
  localparam ctrl_t C_EX_ORI   = '{aluOp:3'b010, aluSrc:1'b1, extOp:1'b1, default:'0};
  localparam ctrl_t C_WB_ORI   = '{aluOp:3'b010, aluSrc:1'b1, extOp:1'b1, regWrite:1'b1, retire:1'b1, default:'0};
  localparam ctrl_t C_EX_LUI   = '{aluOp:3'b011, aluSrc:1'b1, extOp:1'b1, default:'0};
  localparam ctrl_t C_WB_LUI   = '{aluOp:3'b011, aluSrc:1'b1, extOp:1'b1, regWrite:1'b1, retire:1'b1, default:'0};
  localparam ctrl_t C_EX_LS    = '{aluSrc:1'b1, default:'0};
  localparam ctrl_t C_MEM_WAIT = '{memReq:1'b1, aluSrc:1'b1, default:'0};
  localparam ctrl_t C_MEM_SW   = '{memReq:1'b1, aluSrc:1'b1, memWrite:1'b1, retire:1'b1, default:'0};
  localparam ctrl_t C_WB_LW    = '{regWrite:1'b1, memtoReg:1'b1, retire:1'b1, default:'0};
  localparam ctrl_t C_BEQ_T    = '{aluOp:3'b001, pcSrc:2'b01, pcWrite:1'b1, retire:1'b1, default:'0};
  localparam ctrl_t C_BEQ_N    = '{aluOp:3'b001, pcSrc:2'b01, retire:1'b1, default:'0};
  localparam ctrl_t C_J        = '{pcWrite:1'b1, pcSrc:2'b10, retire:1'b1, default:'0};
  localparam ctrl_t C_JAL      = '{pcWrite:1'b1, pcSrc:2'b10, regWrite:1'b1, writeR31:1'b1, retire:1'b1, default:'0};
  localparam ctrl_t C_JR       = '{pcWrite:1'b1, pcSrc:2'b11, retire:1'b1, default:'0};
  localparam ctrl_t C_ILL      = '{illegal:1'b1, default:'0};
  localparam ctrl_t C_ILL_NOP  = '{illegal:1'b1, retire:1'b1, default:'0};

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         n;
    logic [2:0] st[5];
    ctrl_t      ct[5];
  } vec_t;

  typedef struct {
    string       name;
    logic        mr;
    logic [2:0]  st;
    ctrl_t       ct;
    logic [31:0] cnt;
    bit          chkB;
  } cyc_t;

  vec_t vecs[$];
  cyc_t stimQ[$];
  cyc_t sbQ[$];
  int tests = 0;
  int fails = 0;
  logic [31:0] cntExp = '0;
  bit watchMw = 1'b0;
  bit mwSeen = 1'b0;

  always @(ifA.MemWrite or ifB.MemWrite)
    if (watchMw && (ifA.MemWrite === 1'b1 || ifB.MemWrite === 1'b1)) mwSeen = 1'b1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic addVec(input string nm, input logic [5:0] op, input logic [5:0] fn, input logic z,
                        input int n, input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] s3,
                        input logic [2:0] s4, input ctrl_t c1, input ctrl_t c2, input ctrl_t c3,
                        input ctrl_t c4);
    vec_t v;
    v.name = nm; v.op = op; v.fn = fn; v.z = z; v.n = n;
    v.st[0] = S_FETCH; v.st[1] = s1; v.st[2] = s2; v.st[3] = s3; v.st[4] = s4;
    v.ct[0] = C_FETCH; v.ct[1] = c1; v.ct[2] = c2; v.ct[3] = c3; v.ct[4] = c4;
    vecs.push_back(v);
  endtask

  task automatic addCyc(input string nm, input logic mr, input logic [2:0] st, input ctrl_t ct, input bit chkB);
    cyc_t r;
    r.name = nm; r.mr = mr; r.st = st; r.ct = ct; r.cnt = cntExp; r.chkB = chkB;
    stimQ.push_back(r);
    if (ct.retire) cntExp = cntExp + 32'd1;
  endtask

  task automatic compareRec(input cyc_t r);
    check({r.name, ".A.state"}, {29'd0, ifA.state}, {29'd0, r.st});
    check({r.name, ".A.ctrl"}, 32'(actA), 32'(r.ct));
    check({r.name, ".A.cnt"}, ifA.instr_cnt, r.cnt);
    if (r.chkB) begin
      check({r.name, ".B.state"}, {29'd0, ifB.state}, {29'd0, r.st});
      check({r.name, ".B.ctrl"}, 32'(actB), 32'(r.ct));
      check({r.name, ".B.cnt"}, {30'd0, ifB.instr_cnt}, {30'd0, r.cnt[1:0]});
    end
  endtask

  // Entered just after a rising edge; each record spans exactly one clock.
  task automatic runStim();
    cyc_t r, e;
    while (stimQ.size() > 0) begin
      r = stimQ.pop_front();
      memReady = r.mr;
      sbQ.push_back(r);
      @(negedge clk);
      e = sbQ.pop_front();
      compareRec(e);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    addVec("addu", 6'b000000, 6'b100001, 1'b0, 4, S_DEC, S_EXEC, S_WB, 3'd0, C_ZERO, C_ZERO, C_WB_R, C_ZERO);
    addVec("subu", 6'b000000, 6'b100011, 1'b0, 4, S_DEC, S_EXEC, S_WB, 3'd0, C_ZERO, C_EX_SUB, C_WB_R, C_ZERO);
    addVec("nop",  6'b000000, 6'b000000, 1'b0, 4, S_DEC, S_EXEC, S_WB, 3'd0, C_ZERO, C_EX_SLL, C_WB_R, C_ZERO);
    addVec("ori",  6'b001101, 6'b010101, 1'b0, 4, S_DEC, S_EXEC, S_WB, 3'd0, C_ZERO, C_EX_ORI, C_WB_ORI, C_ZERO);
    addVec("lui",  6'b001111, 6'b000000, 1'b0, 4, S_DEC, S_EXEC, S_WB, 3'd0, C_ZERO, C_EX_LUI, C_WB_LUI, C_ZERO);
    addVec("sw",   6'b101011, 6'b000100, 1'b0, 4, S_DEC, S_EXEC, S_MEM, 3'd0, C_ZERO, C_EX_LS, C_MEM_SW, C_ZERO);
    addVec("lw",   6'b100011, 6'b000100, 1'b0, 5, S_DEC, S_EXEC, S_MEM, S_WB, C_ZERO, C_EX_LS, C_MEM_WAIT, C_WB_LW);
    addVec("beqT", 6'b000100, 6'b000000, 1'b1, 3, S_DEC, S_EXEC, 3'd0, 3'd0, C_ZERO, C_BEQ_T, C_ZERO, C_ZERO);
    addVec("beqN", 6'b000100, 6'b000000, 1'b0, 3, S_DEC, S_EXEC, 3'd0, 3'd0, C_ZERO, C_BEQ_N, C_ZERO, C_ZERO);
    addVec("j",    6'b000010, 6'b111111, 1'b0, 2, S_DEC, 3'd0, 3'd0, 3'd0, C_J, C_ZERO, C_ZERO, C_ZERO);
    addVec("jal",  6'b000011, 6'b000000, 1'b0, 2, S_DEC, 3'd0, 3'd0, 3'd0, C_JAL, C_ZERO, C_ZERO, C_ZERO);
    addVec("jr",   6'b000000, 6'b001000, 1'b1, 2, S_DEC, 3'd0, 3'd0, 3'd0, C_JR, C_ZERO, C_ZERO, C_ZERO);

    // Reset state: everything quiet even with memory ready.
    memReady = 1'b1;
    #12;
    check("reset.A.ctrl", 32'(actA), 32'(C_ZERO));
    check("reset.B.ctrl", 32'(actB), 32'(C_ZERO));
    check("reset.A.state", {29'd0, ifA.state}, 32'd0);
    check("reset.A.cnt", ifA.instr_cnt, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    foreach (vecs[i]) begin
      opCode = vecs[i].op;
      funct = vecs[i].fn;
      aluZero = vecs[i].z;
      for (int k = 0; k < vecs[i].n; k++) addCyc(vecs[i].name, 1'b1, vecs[i].st[k], vecs[i].ct[k], 1'b1);
      runStim();
      $display("[TB] %s retired, expected instr_cnt now %0d", vecs[i].name, cntExp);
    end

    // lw with three MEM wait cycles: 8 cycles total.
    opCode = 6'b100011; funct = 6'b000000; aluZero = 1'b0;
    addCyc("lwStall", 1'b1, S_FETCH, C_FETCH, 1'b1);
    addCyc("lwStall", 1'b1, S_DEC, C_ZERO, 1'b1);
    addCyc("lwStall", 1'b1, S_EXEC, C_EX_LS, 1'b1);
    for (int k = 0; k < 3; k++) addCyc("lwStall", 1'b0, S_MEM, C_MEM_WAIT, 1'b1);
    addCyc("lwStall", 1'b1, S_MEM, C_MEM_WAIT, 1'b1);
    addCyc("lwStall", 1'b1, S_WB, C_WB_LW, 1'b1);
    runStim();
    $display("[TB] lwStall retired, expected instr_cnt now %0d", cntExp);

    // sw with two FETCH wait cycles and one MEM wait cycle.
    opCode = 6'b101011;
    addCyc("swStall", 1'b0, S_FETCH, C_FWAIT, 1'b1);
    addCyc("swStall", 1'b0, S_FETCH, C_FWAIT, 1'b1);
    addCyc("swStall", 1'b1, S_FETCH, C_FETCH, 1'b1);
    addCyc("swStall", 1'b1, S_DEC, C_ZERO, 1'b1);
    addCyc("swStall", 1'b1, S_EXEC, C_EX_LS, 1'b1);
    addCyc("swStall", 1'b0, S_MEM, C_MEM_WAIT, 1'b1);
    addCyc("swStall", 1'b1, S_MEM, C_MEM_SW, 1'b1);
    runStim();
    $display("[TB] swStall retired, expected instr_cnt now %0d", cntExp);

    // Reset while a store waits in MEM: the store must never be issued.
    addCyc("swRst", 1'b1, S_FETCH, C_FETCH, 1'b1);
    addCyc("swRst", 1'b1, S_DEC, C_ZERO, 1'b1);
    addCyc("swRst", 1'b1, S_EXEC, C_EX_LS, 1'b1);
    runStim();
    watchMw = 1'b1;
    memReady = 1'b0;
    @(negedge clk);
    check("swRst.preA.state", {29'd0, ifA.state}, {29'd0, S_MEM});
    check("swRst.preA.ctrl", 32'(actA), 32'(C_MEM_WAIT));
    #2 reset = 1'b0;
    #1;
    check("swRst.inA.ctrl", 32'(actA), 32'(C_ZERO));
    check("swRst.inB.ctrl", 32'(actB), 32'(C_ZERO));
    check("swRst.inA.state", {29'd0, ifA.state}, 32'd0);
    check("swRst.inA.cnt", ifA.instr_cnt, 32'd0);
    check("swRst.inB.cnt", {30'd0, ifB.instr_cnt}, 32'd0);
    memReady = 1'b1;
    @(posedge clk);
    #1;
    check("swRst.holdA.ctrl", 32'(actA), 32'(C_ZERO));
    memReady = 1'b0;
    reset = 1'b1;
    cntExp = '0;
    addCyc("afterRst", 1'b0, S_FETCH, C_FWAIT, 1'b1);
    runStim();
    watchMw = 1'b0;
    check("swRst.memWriteSeen", {31'd0, mwSeen}, 32'd0);
    $display("[TB] swRst aborted, expected instr_cnt now %0d", cntExp);

    opCode = 6'b000000; funct = 6'b100001;
    addCyc("addu2", 1'b1, S_FETCH, C_FETCH, 1'b1);
    addCyc("addu2", 1'b1, S_DEC, C_ZERO, 1'b1);
    addCyc("addu2", 1'b1, S_EXEC, C_ZERO, 1'b1);
    addCyc("addu2", 1'b1, S_WB, C_WB_R, 1'b1);
    runStim();
    $display("[TB] addu2 retired, expected instr_cnt now %0d", cntExp);

    // Illegal encoding: A parks in HALT, B retires it as a nop.
    opCode = 6'b111111; funct = 6'b000000;
    addCyc("ill", 1'b1, S_FETCH, C_FETCH, 1'b1);
    runStim();
    @(negedge clk);
    check("ill.dec.A.state", {29'd0, ifA.state}, {29'd0, S_DEC});
    check("ill.dec.A.ctrl", 32'(actA), 32'(C_ILL));
    check("ill.dec.B.ctrl", 32'(actB), 32'(C_ILL_NOP));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("ill.halt.A.state", {29'd0, ifA.state}, {29'd0, S_HALT});
    check("ill.halt.A.ctrl", 32'(actA), 32'(C_ZERO));
    check("ill.nop.B.state", {29'd0, ifB.state}, {29'd0, S_FETCH});
    check("ill.nop.B.cnt", {30'd0, ifB.instr_cnt}, {30'd0, cntExp[1:0] + 2'd1});
    @(posedge clk);
    #1;
    for (int k = 0; k < 9; k++) addCyc("halt", 1'b1, S_HALT, C_ZERO, 1'b0);
    runStim();
    $display("[TB] illegal handled, expected instr_cnt still %0d", cntExp);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
